// File: rtl/store_narrow_unit_pkg.sv
// Shared encodings and helpers for the narrowing store path.
package store_narrow_unit_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Index of the final byte for a legal size (N-1).
  function automatic logic [1:0] size_last_idx(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_last_idx = 2'd0;
      SZ_HALF: size_last_idx = 2'd1;
      default: size_last_idx = 2'd3;
    endcase
  endfunction

  // Little-endian byte lane select.
  function automatic logic [7:0] byte_sel(input logic [31:0] data, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_sel = data[7:0];
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
  endfunction

endpackage

// File: rtl/store_narrow_unit_fit_check.sv
// Combinational fit/alignment check: inverse of the load sign/zero-extend rule.
module narrow_fit_check
  import store_narrow_unit_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  addr_lo,
  output logic        fits,
  output logic        align_ok
);

  // Value fits if the dropped upper bits are a pure sign/zero extension.
  always_comb begin
    fits     = 1'b1;
    align_ok = 1'b0;
    case (size)
      SZ_BYTE: begin
        fits     = sgn ? (data[31:8] == {24{data[7]}}) : (data[31:8] == 24'd0);
        align_ok = 1'b1;
      end
      SZ_HALF: begin
        fits     = sgn ? (data[31:16] == {16{data[15]}}) : (data[31:16] == 16'd0);
        align_ok = ~addr_lo[0];
      end
      SZ_WORD: begin
        fits     = 1'b1;
        align_ok = (addr_lo == 2'b00);
      end
      default: begin
        fits     = 1'b1;
        align_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Narrowing store: fit check at accept, then byte-serial little-endian write.
module store_narrow_unit
  import store_narrow_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_byte,
  output logic              mem_last,
  output logic              done,
  output logic              trunc_err,
  output logic              align_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [CNT_W-1:0]  idx_q, idx_d, last_q, last_d, idx_nxt;
  logic              trunc_q, trunc_d;
  logic              mem_valid_q, mem_valid_d, mem_last_q, mem_last_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_byte_q, mem_byte_d;
  logic              done_q, done_d, trunc_err_q, trunc_err_d, align_err_q, align_err_d;
  logic              fits, align_ok, mem_hs;

  narrow_fit_check u_fit (
    .data     (req_data),
    .size     (req_size),
    .sgn      (req_signed),
    .addr_lo  (req_addr[1:0]),
    .fits     (fits),
    .align_ok (align_ok)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign mem_hs    = mem_valid_q & mem_ready;
  assign idx_nxt   = idx_q + 1'b1;

  // Next-state and next registered outputs; memory port held unless a handshake occurs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    idx_d       = idx_q;
    last_d      = last_q;
    trunc_d     = trunc_q;
    mem_valid_d = mem_valid_q;
    mem_last_d  = mem_last_q;
    mem_addr_d  = mem_addr_q;
    mem_byte_d  = mem_byte_q;
    done_d      = 1'b0;
    trunc_err_d = 1'b0;
    align_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_data;
          trunc_d = ~fits;
          if (!align_ok) begin
            state_d     = ST_ERR;
            done_d      = 1'b1;
            align_err_d = 1'b1;
          end else begin
            state_d     = ST_SEND;
            idx_d       = '0;
            last_d      = size_last_idx(req_size);
            mem_valid_d = 1'b1;
            mem_addr_d  = req_addr;
            mem_byte_d  = req_data[7:0];
            mem_last_d  = (size_last_idx(req_size) == 2'd0);
          end
        end
      end
      ST_SEND: begin
        if (mem_hs) begin
          if (mem_last_q) begin
            state_d     = ST_DONE;
            mem_valid_d = 1'b0;
            mem_last_d  = 1'b0;
            done_d      = 1'b1;
            trunc_err_d = trunc_q;
          end else begin
            idx_d      = idx_nxt;
            mem_addr_d = addr_q + {{(ADDR_W-CNT_W){1'b0}}, idx_nxt};
            mem_byte_d = byte_sel(data_q, idx_nxt);
            mem_last_d = (idx_nxt == last_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      trunc_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_last_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_byte_q  <= '0;
      done_q      <= 1'b0;
      trunc_err_q <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      trunc_q     <= trunc_d;
      mem_valid_q <= mem_valid_d;
      mem_last_q  <= mem_last_d;
      mem_addr_q  <= mem_addr_d;
      mem_byte_q  <= mem_byte_d;
      done_q      <= done_d;
      trunc_err_q <= trunc_err_d;
      align_err_q <= align_err_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_last  = mem_last_q;
  assign mem_addr  = mem_addr_q;
  assign mem_byte  = mem_byte_q;
  assign done      = done_q;
  assign trunc_err = trunc_err_q;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: directed cases plus randomized requests vs a range-based model.
module tb_store_narrow_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid, req_ready, req_signed;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_size;
  logic        mem_valid, mem_ready, mem_last;
  logic [31:0] mem_addr;
  logic [7:0]  mem_byte;
  logic        done, trunc_err, align_err;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  store_narrow_unit #(.ADDR_W(32), .CNT_W(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size), .req_signed(req_signed),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_byte(mem_byte), .mem_last(mem_last),
    .done(done), .trunc_err(trunc_err), .align_err(align_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: byte count, alignment and fit from numeric ranges.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                                input logic sg, output int n, output bit al, output bit tr);
    longint v, lim;
    n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    al = (sz == 2'b11) || ((a % n) != 0);
    lim = longint'(1) << (8*n - 1);
    if (n == 4) tr = 1'b0;
    else if (sg) begin
      v  = longint'($signed(d));
      tr = (v < -lim) || (v >= lim);
    end else tr = (longint'(d) >= 2*lim);
  endfunction

  // One full request; outputs sampled on the falling edge, inputs changed there too.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                        input logic sg, input int pct, input int stall_k, input int stall_n);
    int n, k, cyc, stalls;
    bit al, tr;
    logic [31:0] ea;
    model(a, d, sz, sg, n, al, tr);
    @(negedge Clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_addr = a; req_data = d; req_size = sz; req_signed = sg;
    mem_ready = $urandom_range(1);
    @(negedge Clk);
    req_valid = 0; req_data = $urandom; req_addr = $urandom;
    if (al) begin
      chk("err_mem_valid", mem_valid, 0);
      chk("err_done", done, 1);
      chk("err_align", align_err, 1);
      chk("err_trunc", trunc_err, 0);
      chk("err_busy", req_ready, 0);
      @(negedge Clk);
      chk("err_done_clear", done, 0);
      chk("err_ready_back", req_ready, 1);
      chk("err_mem_valid2", mem_valid, 0);
      return;
    end
    k = 0; cyc = 0; stalls = 0;
    while (k < n && cyc < 200) begin
      ea = a + 32'(k);
      chk("mem_valid", mem_valid, 1);
      chk("mem_addr", mem_addr, ea);
      chk("mem_byte", mem_byte, (d >> (8*k)) & 32'hFF);
      chk("mem_last", mem_last, (k == n-1));
      chk("done_low", done, 0);
      if (k == stall_k && stalls < stall_n) begin
        mem_ready = 0; stalls++;
      end else mem_ready = ($urandom_range(99) >= pct);
      if (mem_ready) k++;
      cyc++;
      @(negedge Clk);
    end
    if (cyc >= 200) chk("send_timeout", 1, 0);
    chk("done", done, 1);
    chk("trunc_err", trunc_err, tr);
    chk("align_clear", align_err, 0);
    chk("mem_valid_off", mem_valid, 0);
    mem_ready = $urandom_range(1);
    @(negedge Clk);
    chk("done_pulse", done, 0);
    chk("ready_after", req_ready, 1);
  endtask

  initial begin
    int n; bit al, tr;
    logic [31:0] a, d;
    logic [1:0]  sz;
    Reset = 1; req_valid = 0; req_addr = 0; req_data = 0; req_size = 0; req_signed = 0; mem_ready = 0;
    repeat (2) @(negedge Clk);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_last", mem_last, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_byte", mem_byte, 0);
    chk("rst_flags", {done, trunc_err, align_err}, 0);
    chk("rst_ready", req_ready, 1);
    Reset = 0;

    // Directed cases.
    do_req(32'h13, 32'hFFFFFF80, 2'b00, 1, 0, -1, 0);
    do_req(32'h100, 32'h00012345, 2'b01, 0, 0, -1, 0);
    do_req(32'h40, 32'hDEADBEEF, 2'b10, 0, 0, 1, 3);
    do_req(32'h201, 32'h00000001, 2'b01, 0, 0, -1, 0);
    do_req(32'h0, 32'h12345678, 2'b11, 1, 0, -1, 0);
    do_req(32'hFFFFFFFC, 32'hA1B2C3D4, 2'b10, 1, 0, -1, 0);
    do_req(32'h7, 32'h0000007F, 2'b00, 1, 0, -1, 0);
    do_req(32'h8, 32'h00000080, 2'b00, 1, 0, -1, 0);
    do_req(32'hA, 32'hFFFF8000, 2'b01, 1, 0, -1, 0);

    // Reset during a word store after its second byte.
    @(negedge Clk);
    req_valid = 1; req_addr = 32'h80; req_data = 32'h11223344; req_size = 2'b10; req_signed = 0;
    mem_ready = 1;
    @(negedge Clk);
    req_valid = 0;
    chk("rst_mid_b0", mem_byte, 8'h44);
    @(negedge Clk);
    chk("rst_mid_b1", mem_byte, 8'h33);
    Reset = 1;
    @(negedge Clk);
    Reset = 0;
    chk("rst_mid_valid", mem_valid, 0);
    chk("rst_mid_outs", {mem_last, mem_addr, mem_byte, done, trunc_err, align_err}, 0);
    chk("rst_mid_ready", req_ready, 1);
    @(negedge Clk);
    chk("rst_mid_nodone", done, 0);
    chk("rst_mid_novalid", mem_valid, 0);
    do_req(32'h55, 32'h000000AB, 2'b00, 0, 0, -1, 0);

    // Randomized requests with random backpressure.
    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(3));
      a  = $urandom;
      if ($urandom_range(3) != 0) a = a & ~32'h3;
      case ($urandom_range(3))
        0: d = $urandom;
        1: d = 32'($signed(8'($urandom)));
        2: d = 32'($signed(16'($urandom)));
        default: d = {16'h0, 16'($urandom)};
      endcase
      model(a, d, sz, 1'b0, n, al, tr);
      do_req(a, d, sz, 1'($urandom_range(1)), 30, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
